// File: rtl/clk_period_meter.sv
// clk_period_meter: measures high time, low time and period of a slow asynchronous
// square wave in clk cycles; results delivered over a valid/ready handshake.
`default_nettype none

module clk_period_meter #(
  parameter int N           = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_sig,
  output logic [N-1:0] high_len,
  output logic [N-1:0] low_len,
  output logic [N:0]   period,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         timeout,
  output logic         overrun
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall;
  logic [N-1:0]           cnt, cnt_next;
  logic [N-1:0]           hi_tmp, hi_tmp_next;
  logic                   capture, sat_hit, flag_clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_sig};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    hi_tmp_next = hi_tmp;
    capture     = 1'b0;
    sat_hit     = 1'b0;
    flag_clear  = 1'b0;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = WAIT_RISE;
          flag_clear = 1'b1;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_next   = CNT_ONE;
            state_next = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            hi_tmp_next = cnt;
            cnt_next    = CNT_ONE;
            state_next  = MEAS_LOW;
          end else if (cnt == CNT_MAX) begin
            sat_hit    = 1'b1;
            cnt_next   = '0;
            state_next = WAIT_RISE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            capture    = 1'b1;
            cnt_next   = CNT_ONE;
            state_next = MEAS_HIGH;
          end else if (cnt == CNT_MAX) begin
            sat_hit    = 1'b1;
            cnt_next   = '0;
            state_next = WAIT_RISE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_tmp       <= '0;
      high_len     <= '0;
      low_len      <= '0;
      period       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      hi_tmp <= hi_tmp_next;
      // A capture in the same cycle as an accept keeps valid high without overrun.
      if (!en) begin
        result_valid <= 1'b0;
      end else if (capture) begin
        high_len     <= hi_tmp;
        low_len      <= cnt;
        period       <= {1'b0, hi_tmp} + {1'b0, cnt};
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if (flag_clear) begin
        timeout <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (sat_hit)
          timeout <= 1'b1;
        if (capture && result_valid && !result_ready)
          overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
// Directed self-checking bench for clk_period_meter (default N and an N=4 instance).
`default_nettype none

module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst, en, in_sig, result_ready;
  logic [27:0] high_len, low_len;
  logic [28:0] period;
  logic        result_valid, timeout, overrun;
  logic [3:0]  high_len4, low_len4;
  logic [4:0]  period4;
  logic        result_valid4, timeout4, overrun4;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  clk_period_meter #(.N(28), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_sig(in_sig),
    .high_len(high_len), .low_len(low_len), .period(period),
    .result_valid(result_valid), .result_ready(result_ready),
    .timeout(timeout), .overrun(overrun)
  );

  clk_period_meter #(.N(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_sig(in_sig),
    .high_len(high_len4), .low_len(low_len4), .period(period4),
    .result_valid(result_valid4), .result_ready(result_ready),
    .timeout(timeout4), .overrun(overrun4)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_level(input logic v, input int n);
    in_sig = v;
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; in_sig = 1'b0; result_ready = 1'b0;
    apply_reset();
    n_checks++;
    if ({high_len, low_len, period, result_valid, timeout, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got h=%0d l=%0d p=%0d v=%0b t=%0b o=%0b want all 0",
                         high_len, low_len, period, result_valid, timeout, overrun);
    end
    n_checks++;
    if ({high_len4, low_len4, period4, result_valid4, timeout4, overrun4} !== '0) begin
      n_fail++; $display("FAIL reset_outputs4: got nonzero outputs, want all 0");
    end
  endtask

  task automatic test_square_wave();
    int pulses, last;
    apply_reset();
    result_ready = 1'b1; en = 1'b1; in_sig = 1'b0;
    repeat (3) step();
    pulses = 0; last = -1;
    for (int c = 0; c < 48; c++) begin
      in_sig = ((c / 4) % 2 == 0);
      step();
      if (result_valid) begin
        pulses++;
        n_checks++;
        if (high_len !== 28'd4 || low_len !== 28'd4 || period !== 29'd8) begin
          n_fail++; $display("FAIL sq_values: got %0d/%0d/%0d want 4/4/8", high_len, low_len, period);
        end
        if (last >= 0) begin
          n_checks++;
          if (c - last != 8) begin
            n_fail++; $display("FAIL sq_spacing: got %0d want 8", c - last);
          end
        end
        last = c;
      end
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++; $display("FAIL sq_pulses: got %0d want 5", pulses);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    result_ready = 1'b0; en = 1'b1; in_sig = 1'b0;
    repeat (3) step();
    drive_level(1'b1, 3); drive_level(1'b0, 10);
    drive_level(1'b1, 3); drive_level(1'b0, 2);
    n_checks++;
    if (result_valid !== 1'b1 || high_len !== 28'd3 || low_len !== 28'd10 || period !== 29'd13 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_first: got v=%0b %0d/%0d/%0d o=%0b want v=1 3/10/13 o=0",
                         result_valid, high_len, low_len, period, overrun);
    end
    drive_level(1'b0, 8);
    drive_level(1'b1, 3); drive_level(1'b0, 2);
    n_checks++;
    if (result_valid !== 1'b1 || high_len !== 28'd3 || low_len !== 28'd10 || period !== 29'd13 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_second: got v=%0b %0d/%0d/%0d o=%0b want v=1 3/10/13 o=1",
                         result_valid, high_len, low_len, period, overrun);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    result_ready = 1'b0; en = 1'b1; in_sig = 1'b0;
    repeat (3) step();
    drive_level(1'b1, 17);
    n_checks++;
    if (timeout4 !== 1'b0) begin
      n_fail++; $display("FAIL to_early: got %0b want 0", timeout4);
    end
    drive_level(1'b1, 3);
    n_checks++;
    if (timeout4 !== 1'b1 || result_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL to_set: got t=%0b v=%0b want t=1 v=0", timeout4, result_valid4);
    end
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_wide: got %0b want 0", timeout);
    end
    drive_level(1'b0, 5); drive_level(1'b1, 5); drive_level(1'b0, 5); drive_level(1'b1, 5);
    n_checks++;
    if (result_valid4 !== 1'b1 || high_len4 !== 4'd5 || low_len4 !== 4'd5 || period4 !== 5'd10 || timeout4 !== 1'b1) begin
      n_fail++; $display("FAIL to_resume: got v=%0b %0d/%0d/%0d t=%0b want v=1 5/5/10 t=1",
                         result_valid4, high_len4, low_len4, period4, timeout4);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    result_ready = 1'b0; en = 1'b1; in_sig = 1'b0;
    repeat (3) step();
    drive_level(1'b1, 4); drive_level(1'b0, 6);
    drive_level(1'b1, 5); drive_level(1'b0, 7);
    in_sig = 1'b1;
    step(); step();
    n_checks++;
    if (result_valid !== 1'b1 || high_len !== 28'd4 || low_len !== 28'd6 || period !== 29'd10) begin
      n_fail++; $display("FAIL b2b_old: got v=%0b %0d/%0d/%0d want v=1 4/6/10",
                         result_valid, high_len, low_len, period);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || high_len !== 28'd5 || low_len !== 28'd7 || period !== 29'd12 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL b2b_new: got v=%0b %0d/%0d/%0d o=%0b want v=1 5/7/12 o=0",
                         result_valid, high_len, low_len, period, overrun);
    end
    drive_level(1'b1, 2);
  endtask

  task automatic test_enable_drop();
    apply_reset();
    result_ready = 1'b0; en = 1'b1; in_sig = 1'b0;
    repeat (3) step();
    drive_level(1'b1, 4); drive_level(1'b0, 4);
    drive_level(1'b1, 4); drive_level(1'b0, 4);
    drive_level(1'b1, 4); drive_level(1'b0, 4);
    en = 1'b0;
    step();
    n_checks++;
    if (result_valid !== 1'b0 || overrun !== 1'b1 || high_len !== 28'd4 || period !== 29'd8) begin
      n_fail++; $display("FAIL en_drop: got v=%0b o=%0b h=%0d p=%0d want v=0 o=1 h=4 p=8",
                         result_valid, overrun, high_len, period);
    end
    step(); step();
    en = 1'b1;
    step();
    n_checks++;
    if (overrun !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL en_flags: got o=%0b t=%0b want 0 0", overrun, timeout);
    end
    drive_level(1'b1, 4); drive_level(1'b0, 4);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_one_rise: got v=%0b want 0", result_valid);
    end
    drive_level(1'b1, 4);
    n_checks++;
    if (result_valid !== 1'b1 || high_len !== 28'd4 || low_len !== 28'd4 || period !== 29'd8) begin
      n_fail++; $display("FAIL en_two_rise: got v=%0b %0d/%0d/%0d want v=1 4/4/8",
                         result_valid, high_len, low_len, period);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    result_ready = 1'b0; en = 1'b1; in_sig = 1'b0;
    repeat (3) step();
    drive_level(1'b1, 4); drive_level(1'b0, 4);
    drive_level(1'b1, 4);
    n_checks++;
    if (result_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got v=%0b want 1", result_valid);
    end
    rst = 1'b1; in_sig = 1'b0;
    step();
    rst = 1'b0;
    n_checks++;
    if ({high_len, low_len, period, result_valid, timeout, overrun} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got h=%0d l=%0d p=%0d v=%0b want all 0",
                         high_len, low_len, period, result_valid);
    end
    drive_level(1'b0, 4);
    drive_level(1'b1, 5); drive_level(1'b0, 5); drive_level(1'b1, 5);
    n_checks++;
    if (result_valid !== 1'b1 || high_len !== 28'd5 || low_len !== 28'd5 || period !== 29'd10) begin
      n_fail++; $display("FAIL rst_resume: got v=%0b %0d/%0d/%0d want v=1 5/5/10",
                         result_valid, high_len, low_len, period);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_sig = 1'b0; result_ready = 1'b0;
    step();
    test_reset();
    test_square_wave();
    test_overrun();
    test_timeout();
    test_back_to_back();
    test_enable_drop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
